burst_read_arbiter: RTL and testbench
=====================================

// Module: burst_read_arbiter
// PURPOSE
//  Shares one burst_read_pipeline between NUM_REQ burst-read requesters.
//  Round-robin arbitration on request side; drives pipeline u_* port.
//  Returned beats (d_*) are routed back to the issuing requester.
//  Routing uses an in-order ID FIFO; the pipeline returns bursts in issue order.
// PARAMETERS
//  NUM_REQ           4   number of requesters (2..8)
//  DATA_WIDTH        32  data width
//  ADDR_WIDTH        32  address width
//  MAX_BURST_LENGTH  4   pipeline max beats per burst; length field = beats-1
//  OUTSTANDING       4   ID FIFO depth = max bursts in flight (power of 2)
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   async reset, active low
//  req_addr     in   NUM_REQ*ADDR_WIDTH  per-requester start address, packed, req0 at LSB
//  req_length   in   NUM_REQ*8           per-requester beats-1
//  req_valid    in   NUM_REQ             request valid
//  req_ready    out  NUM_REQ             request accepted (one-hot or zero)
//  u_addr       out  ADDR_WIDTH          to pipeline u_addr
//  u_length     out  8                   to pipeline u_length
//  u_valid      out  1                   to pipeline u_valid
//  u_ready      in   1                   from pipeline u_ready
//  d_data       in   DATA_WIDTH          from pipeline d_data
//  d_valid      in   1                   from pipeline d_valid
//  d_last       in   1                   from pipeline d_last
//  d_ready      out  1                   to pipeline d_ready
//  rsp_data     out  DATA_WIDTH          shared response data (broadcast)
//  rsp_valid    out  NUM_REQ             per-requester beat valid
//  rsp_last     out  1                   last beat of burst
//  rsp_ready    in   NUM_REQ             per-requester beat ready
//  err_orphan   out  1                   sticky: d_valid seen while ID FIFO empty
// BEHAVIOUR
//  Reset: u_valid=0, u_addr/u_length=0, rr pointer=0, FIFO empty, err_orphan=0.
//  Issue slot free when !u_valid || u_ready.
//  Grant when slot free && FIFO not full && |req_valid. The winner is the first valid requester
//   at or after the rr pointer (mod NUM_REQ). req_ready[g]=1 is combinational in the same cycle.
//  On grant: u_addr/u_length/u_valid are registered next cycle (1-cycle latency),
//   g is pushed to the FIFO, and rr pointer becomes g+1 mod NUM_REQ.
//  No grant while slot free: u_valid<=0. While u_valid && !u_ready: u_* held stable.
//  FIFO full: no grant, even if a pop occurs in the same cycle (deterministic throttle).
//  Response routing is combinational from the FIFO head h:
//   rsp_valid[h]=d_valid && !empty, all other bits 0; d_ready=rsp_ready[h] && !empty.
//   rsp_data=d_data; rsp_last=d_last.
//  Pop when d_valid && d_ready && d_last. Push and pop in the same cycle: count unchanged.
//  Empty FIFO with d_valid: d_ready=0 and err_orphan<=1 (cleared only by reset).
//  Reset mid-burst: all state cleared; the pipeline shares rst_n, so no in-flight beats survive.
// CONFIGURATION
//  BURST_ARB_LEN_CLAMP_EN defined:
//   u_length = min(req_length, MAX_BURST_LENGTH-1); the requester expects the clamped beat count.
//  Undefined: req_length is passed through unmodified; caller guarantees range.
// STRUCTURE
//  burst_arb_pkg: ID width localparam/function clog2(NUM_REQ),
//   the length typedef (8b), and the rr-next-winner function.
//  Sub-module burst_arb_id_fifo: sync FIFO (ID width x OUTSTANDING) with push/pop/full/empty/head.
// TESTING
//  1 Single req0 addr=0x10 len=2, d returns 0x10..0x12
//     -> u_valid 1 cycle after req_ready; rsp_valid[0] on 3 beats; last on 0x12.
//  2 req0..req3 all valid every cycle, len=0, u_ready=1
//     -> grants 0,1,2,3,0,... with one grant per cycle when FIFO is not full.
//  3 OUTSTANDING=4, d_valid held low, 5 requests
//     -> 4 grants, then req_ready=0; one pop (d_last) -> next grant the following cycle.
//  4 Randomised rsp_ready stalls (0..3 cycles) on the head requester
//     -> d_ready follows it; rsp_data stable while stalled; no beat on another requester's rsp_valid.
//  5 u_ready=0 for 3 cycles with u_valid=1
//     -> u_addr/u_length held; no new req_ready during the stall.
//  6 d_valid=1 with FIFO empty -> d_ready=0, err_orphan=1 until rst_n.
//     With BURST_ARB_LEN_CLAMP_EN: req_length=7 -> u_length=3.

Source files
------------

// File: rtl/burst_arb_pkg.sv
// burst_arb_pkg: shared types and helpers for the burst read arbiter.
// Holds the burst length type, the requester ID width function,
// the length clamp helper and the round-robin winner search.
package burst_arb_pkg;

    // Largest supported requester count; the winner search is unrolled to this size.
    localparam int MAX_REQ = 8;

    // Burst length field as seen by the pipeline: number of beats minus one.
    typedef logic [7:0] len_t;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

    // Limit a length field to the largest value the pipeline accepts.
    function automatic len_t clamp_len(input len_t len, input len_t limit);
        return (len > limit) ? limit : len;
    endfunction

    // First asserted bit of valid at or after ptr, wrapping modulo num_req.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_winner(input logic [MAX_REQ-1:0] valid,
                                             input logic [2:0]         ptr,
                                             input int                 num_req);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < num_req) begin
                idx = int'(ptr) + i;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end
                if (!found && valid[idx[2:0]]) begin
                    found = 1'b1;
                    win   = idx[2:0];
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/burst_arb_id_fifo.sv
// burst_arb_id_fifo: in-order FIFO of requester IDs for bursts in flight.
// The head entry names the requester that owns the beats currently
// returning from the pipeline. Storage is not reset; only pointers are.
module burst_arb_id_fifo
    import burst_arb_pkg::*;
#(
    parameter int ID_W  = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (int'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ID storage written at the tail slot on each accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/burst_read_arbiter.sv
// burst_read_arbiter: shares one burst read pipeline between NUM_REQ requesters.
// Requests are granted round-robin and issued on the pipeline u_* port with
// one cycle of latency. Returned beats are steered to the issuing requester
// using an in-order ID FIFO, relying on the pipeline returning bursts in order.
// Optional build macro BURST_ARB_LEN_CLAMP_EN: clamp issued lengths to
// MAX_BURST_LENGTH-1; otherwise lengths pass through unchanged.
module burst_read_arbiter
    import burst_arb_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST_LENGTH = 4,
    parameter int OUTSTANDING      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_length,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         u_addr,
    output logic [7:0]                    u_length,
    output logic                          u_valid,
    input  logic                          u_ready,
    input  logic [DATA_WIDTH-1:0]         d_data,
    input  logic                          d_valid,
    input  logic                          d_last,
    output logic                          d_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_last,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          err_orphan
);

    localparam int ID_W = id_width(NUM_REQ);

`ifdef BURST_ARB_LEN_CLAMP_EN
    localparam bit LEN_CLAMP = 1'b1;
`else
    localparam bit LEN_CLAMP = 1'b0;
`endif

    localparam len_t LEN_LIMIT = len_t'(MAX_BURST_LENGTH - 1);

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       grant_id;
    logic [2:0]            win_raw;
    logic                  slot_free;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] grant_addr;
    len_t                  raw_len;
    len_t                  grant_len;

    logic [ID_W-1:0]       head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    // A new burst may be presented when the output register is empty or draining.
    // A full FIFO blocks grants even if it pops this cycle, so throttling does
    // not depend on the response side's timing.
    assign slot_free = !u_valid || u_ready;
    assign grant     = slot_free && !fifo_full && (|req_valid);
    assign win_raw   = rr_winner(8'(req_valid), 3'(rr_ptr), NUM_REQ);
    assign grant_id  = ID_W'(win_raw);
    assign req_ready = grant ? (NUM_REQ'(1) << grant_id) : '0;

    // Select the winner's address and length; clamp the length when enabled.
    always_comb begin
        grant_addr = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
        raw_len    = req_length[int'(grant_id)*8 +: 8];
        grant_len  = LEN_CLAMP ? clamp_len(raw_len, LEN_LIMIT) : raw_len;
    end

    // Issue register toward the pipeline and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_valid  <= 1'b0;
            u_addr   <= '0;
            u_length <= '0;
            rr_ptr   <= '0;
        end else if (grant) begin
            u_valid  <= 1'b1;
            u_addr   <= grant_addr;
            u_length <= grant_len;
            rr_ptr   <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end else if (slot_free) begin
            u_valid  <= 1'b0;
        end
    end

    burst_arb_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (grant),
        .push_id (grant_id),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Steer the returning beat to the FIFO head; with no burst in flight nothing is accepted.
    always_comb begin
        rsp_valid = '0;
        d_ready   = 1'b0;
        if (!fifo_empty) begin
            rsp_valid = d_valid ? (NUM_REQ'(1) << head) : '0;
            d_ready   = rsp_ready[head];
        end
        rsp_data = d_data;
        rsp_last = d_last;
    end

    // The burst retires once its last beat is accepted.
    assign pop = d_valid && d_ready && d_last;

    // Sticky flag for beats arriving with no burst outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan <= 1'b0;
        end else if (d_valid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_burst_read_arbiter.sv
// tb_burst_read_arbiter: scoreboard bench for burst_read_arbiter.
// The bench plays the pipeline: it accepts issued bursts and returns beats
// with data = start address + beat index, one cycle after acceptance.
module tb_burst_read_arbiter;

    localparam int NUM_REQ          = 4;
    localparam int DATA_WIDTH       = 32;
    localparam int ADDR_WIDTH       = 32;
    localparam int MAX_BURST_LENGTH = 4;
    localparam int OUTSTANDING      = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*8-1:0]          req_length;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [ADDR_WIDTH-1:0]         u_addr;
    logic [7:0]                    u_length;
    logic                          u_valid;
    logic                          u_ready;
    logic [DATA_WIDTH-1:0]         d_data;
    logic                          d_valid;
    logic                          d_last;
    logic                          d_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_last;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic                          err_orphan;

    always #5 clk = ~clk;

    burst_read_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .DATA_WIDTH       (DATA_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .MAX_BURST_LENGTH (MAX_BURST_LENGTH),
        .OUTSTANDING      (OUTSTANDING)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_addr   (req_addr),
        .req_length (req_length),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .u_addr     (u_addr),
        .u_length   (u_length),
        .u_valid    (u_valid),
        .u_ready    (u_ready),
        .d_data     (d_data),
        .d_valid    (d_valid),
        .d_last     (d_last),
        .d_ready    (d_ready),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_last   (rsp_last),
        .rsp_ready  (rsp_ready),
        .err_orphan (err_orphan)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Reference model state (values after the next active edge).
    int          m_rr;
    bit          m_uvalid;
    logic [31:0] m_uaddr;
    logic [7:0]  m_ulen;
    bit          m_err;
    int          m_ids[$];
    logic [39:0] iss_q[$];   // expected issued bursts {len, addr}
    logic [39:0] pipe_q[$];  // bursts accepted by the emulated pipeline
    int          beat_idx;
    bit          beat_taken;
    bit          pipe_en;
    bit          rnd_ready;
    int          stall_left;
    bit          prev_stall;
    logic [31:0] prev_data;
    int          rsp_beats[NUM_REQ];
    logic [31:0] last_data;
    int          n_grants;
    int          gseq[$];
    logic [NUM_REQ-1:0] last_req_ready;

    function automatic logic [7:0] exp_len(input logic [7:0] l);
`ifdef BURST_ARB_LEN_CLAMP_EN
        return (l > 8'(MAX_BURST_LENGTH - 1)) ? 8'(MAX_BURST_LENGTH - 1) : l;
`else
        return l;
`endif
    endfunction

    // Called mid-cycle: compare DUT outputs to the model, then advance the model.
    task automatic observe();
        bit          slot;
        bit          gnt;
        int          g;
        int          h;
        logic [NUM_REQ-1:0] exp_rv;
        bit          exp_dr;
        logic [39:0] e;
        logic [31:0] a;
        logic [7:0]  l;
        if (!rst_n) begin
            chk("rst_u_valid", u_valid, 0);
            chk("rst_u_addr", u_addr, 0);
            chk("rst_u_length", u_length, 0);
            chk("rst_err_orphan", err_orphan, 0);
            m_rr = 0; m_uvalid = 0; m_uaddr = 0; m_ulen = 0; m_err = 0;
            m_ids.delete(); iss_q.delete(); pipe_q.delete();
            beat_idx = 0; beat_taken = 0; prev_stall = 0; stall_left = 0;
            return;
        end
        chk("u_valid", u_valid, m_uvalid);
        if (m_uvalid) begin
            chk("u_addr", u_addr, m_uaddr);
            chk("u_length", u_length, m_ulen);
        end
        chk("err_orphan", err_orphan, m_err);
        if (u_valid && u_ready) begin
            if (iss_q.size() == 0) chk("iss_unexpected", 1, 0);
            else begin
                e = iss_q.pop_front();
                chk("iss_addr", u_addr, e[31:0]);
                chk("iss_len", u_length, e[39:32]);
            end
            pipe_q.push_back({u_length, u_addr});
        end
        // arbitration
        slot = !m_uvalid || u_ready;
        gnt  = slot && (m_ids.size() < OUTSTANDING) && (req_valid != 0);
        g    = 0;
        if (gnt) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
            end
        end
        chk("req_ready", req_ready, gnt ? (NUM_REQ'(1) << g) : '0);
        last_req_ready = req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                n_grants++;
                gseq.push_back(i);
            end
        end
        // response routing
        exp_rv = '0;
        exp_dr = 0;
        if (m_ids.size() > 0) begin
            h = m_ids[0];
            exp_rv = d_valid ? (NUM_REQ'(1) << h) : '0;
            exp_dr = rsp_ready[h];
        end
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("d_ready", d_ready, exp_dr);
        if (d_valid) begin
            chk("rsp_data", rsp_data, d_data);
            chk("rsp_last", rsp_last, d_last);
        end
        if (prev_stall) chk("rsp_hold", rsp_data, prev_data);
        prev_stall = pipe_en && d_valid && !exp_dr && (m_ids.size() > 0);
        prev_data  = d_data;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
                rsp_beats[i]++;
                if (rsp_last) last_data = rsp_data;
            end
        end
        beat_taken = d_valid && d_ready;
        // model update for the coming edge
        if (d_valid && m_ids.size() == 0) m_err = 1;
        if (d_valid && exp_dr && d_last && m_ids.size() > 0) void'(m_ids.pop_front());
        if (gnt) begin
            a = req_addr[g*32 +: 32];
            l = exp_len(req_length[g*8 +: 8]);
            m_ids.push_back(g);
            iss_q.push_back({l, a});
            m_uvalid = 1; m_uaddr = a; m_ulen = l;
            m_rr = (g + 1) % NUM_REQ;
        end else if (slot) begin
            m_uvalid = 0;
        end
    endtask

    // Emulated pipeline: one beat per cycle, data = addr + beat index.
    task automatic drive_pipe();
        if (beat_taken && pipe_q.size() > 0) begin
            if (beat_idx == int'(pipe_q[0][39:32])) begin
                void'(pipe_q.pop_front());
                beat_idx = 0;
            end else beat_idx++;
        end
        if (pipe_q.size() > 0) begin
            d_valid = 1;
            d_data  = pipe_q[0][31:0] + 32'(beat_idx);
            d_last  = (beat_idx == int'(pipe_q[0][39:32]));
        end else begin
            d_valid = 0;
            d_last  = 0;
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] r;
        int h;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        if (pipe_en) drive_pipe();
        if (rnd_ready) begin
            r = NUM_REQ'($urandom_range(0, 15));
            h = (m_ids.size() > 0) ? m_ids[0] : 0;
            if (stall_left > 0) begin
                r[h] = 1'b0;
                stall_left--;
            end else begin
                r[h] = 1'b1;
                if ($urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 3);
            end
            rsp_ready = r;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = '0; d_valid = 0; d_last = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((m_ids.size() != 0 || m_uvalid || pipe_q.size() != 0 || d_valid) && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) chk(tag, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_addr = '0; req_length = '0; req_valid = '0; u_ready = 1;
        d_data = '0; d_valid = 0; d_last = 0; rsp_ready = '1;
        pipe_en = 1; rnd_ready = 0; stall_left = 0;
        for (int i = 0; i < NUM_REQ; i++) rsp_beats[i] = 0;
        last_data = '0;
        do_reset();

        // 1: single burst from req0
        req_addr[31:0] = 32'h10; req_length[7:0] = 8'd2; req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        chk("t1_u_valid", u_valid, 0);
        wait_idle("t1_drain");
        chk("t1_beats", rsp_beats[0], 3);
        chk("t1_last", last_data, 32'h12);

        // 2: all requesters valid, single-beat bursts
        do_reset();
        gseq.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*32 +: 32] = 32'h100 * (i + 1);
            req_length[i*8 +: 8] = 8'd0;
        end
        req_valid = '1;
        for (int c = 0; c < 16; c++) step();
        req_valid = '0;
        wait_idle("t2_drain");
        chk("t2_count_ge8", gseq.size() >= 8, 1);
        for (int k = 0; k < 8 && k < gseq.size(); k++) chk("t2_grant", gseq[k], k % NUM_REQ);

        // 3: FIFO full throttle
        do_reset();
        pipe_en = 0; n_grants = 0;
        req_addr[31:0] = 32'h300; req_length[7:0] = 8'd0; req_valid = 4'b0001;
        for (int c = 0; c < 6; c++) step();
        chk("t3_grants", n_grants, 4);
        chk("t3_blocked", req_ready, 0);
        d_data = 32'hAA; d_valid = 1; d_last = 1;
        step();
        d_valid = 0; d_last = 0;
        step();
        chk("t3_regrant", last_req_ready, 4'b0001);
        pipe_en = 1;
        do_reset();

        // 4: random traffic with head-requester stalls
        rnd_ready = 1;
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_addr[i*32 +: 32] = $urandom;
                req_length[i*8 +: 8] = 8'($urandom_range(0, 3));
            end
            req_valid = NUM_REQ'($urandom_range(0, 15));
            u_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0; u_ready = 1;
        wait_idle("t4_drain");
        rnd_ready = 0; rsp_ready = '1;

        // 5: issue stall holds u_* and blocks grants
        do_reset();
        req_addr[31:0] = 32'h500; req_length[7:0] = 8'd1;
        req_addr[63:32] = 32'h600; req_length[15:8] = 8'd0;
        req_valid = 4'b0011;
        step();
        u_ready = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5_hold_addr", u_addr, 32'h500);
            chk("t5_hold_len", u_length, 8'd1);
            chk("t5_no_ready", req_ready, 0);
        end
        u_ready = 1;
        step();
        req_valid = '0;
        wait_idle("t5_drain");

        // 6: orphan beat and length handling
        do_reset();
        pipe_en = 0;
        d_data = 32'hDEAD; d_valid = 1; d_last = 1;
        step();
        chk("t6_dready", d_ready, 0);
        step();
        chk("t6_err", err_orphan, 1);
        d_valid = 0; d_last = 0;
        step(); step();
        chk("t6_sticky", err_orphan, 1);
        req_addr[31:0] = 32'h700; req_length[7:0] = 8'd7; req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("t6_len", u_length, exp_len(8'd7));
        chk("t6_addr", u_addr, 32'h700);
        do_reset();
        chk("t6_err_clr", err_orphan, 0);
        chk("t6_uvalid_clr", u_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
